// File: rtl/reg_cmd_sequencer_if.sv
// Bundles the sequencer's three links: inbound command stream, register-block strobes and response stream.
// Purely structural: no latency and no storage; backpressure is carried by cmd_ready and rsp_ready.
interface reg_cmd_sequencer_if;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] reg_data;
    logic        reg_num_le;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic        reg_illegal;
    logic [31:0] reg_rdata;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;

    modport master (
        input  cmd_data, cmd_valid, reg_illegal, reg_rdata, rsp_ready,
        output cmd_ready, reg_data, reg_num_le, reg_wr_en, reg_rd_en, rsp_data, rsp_valid
    );

    modport slave (
        output cmd_data, cmd_valid, reg_illegal, reg_rdata, rsp_ready,
        input  cmd_ready, reg_data, reg_num_le, reg_wr_en, reg_rd_en, rsp_data, rsp_valid
    );
endinterface

// File: rtl/reg_cmd_sequencer.sv
// Parses burst read/write commands into register-block strobes and returns read data plus a status word.
// Latency: 4 cycles per write access, 5 per read access; cmd_ready/rsp_valid stall both streams as needed.
module reg_cmd_sequencer #(
    parameter int         CNT_W      = 8,
    parameter logic [7:0] STATUS_TAG = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    reg_cmd_sequencer_if.master  bus,
    output logic                 busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, CHECK, WDATA, WR, RD, RWAIT, RSP, DRAIN, STATUS
    } state_t;

    state_t             state, state_n;
    logic               op, op_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [CNT_W-1:0]   done, done_n;
    logic [CNT_W-1:0]   remain, remain_n;
    logic [15:0]        addr, addr_n;
    logic               ill, ill_n;
    logic               bad_hdr, bad_hdr_n;
    logic [31:0]        reg_data_n;
    logic [31:0]        rsp_data_n;
    logic               cmd_fire;
    logic               rsp_fire;

    assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
    assign rsp_fire = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        state_n    = state;
        op_n       = op;
        count_n    = count;
        done_n     = done;
        remain_n   = remain;
        addr_n     = addr;
        ill_n      = ill;
        bad_hdr_n  = bad_hdr;
        reg_data_n = bus.reg_data;
        rsp_data_n = bus.rsp_data;

        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    op_n      = bus.cmd_data[31];
                    count_n   = CNT_W'(bus.cmd_data[23:16]);
                    addr_n    = bus.cmd_data[15:0];
                    done_n    = '0;
                    remain_n  = '0;
                    ill_n     = 1'b0;
                    bad_hdr_n = (bus.cmd_data[30:24] != 7'd0);
                    if (bad_hdr_n || count_n == '0) state_n = STATUS;
                    else                            state_n = ADDR;
                end
            end
            ADDR:  state_n = CHECK;
            CHECK: begin
                if (bus.reg_illegal) begin
                    ill_n = 1'b1;
                    if (op) begin
                        state_n = STATUS;
                    end else begin
                        // Remaining write words must still be pulled off the link.
                        remain_n = count - done;
                        state_n  = DRAIN;
                    end
                end else begin
                    state_n = op ? RD : WDATA;
                end
            end
            WDATA: begin
                if (cmd_fire) begin
                    reg_data_n = bus.cmd_data;
                    state_n    = WR;
                end
            end
            WR: begin
                done_n  = (done == count) ? done : done + 1'b1;
                addr_n  = addr + 16'd1;
                state_n = (done_n == count) ? STATUS : ADDR;
            end
            RD:    state_n = RWAIT;
            RWAIT: begin
                rsp_data_n = bus.reg_rdata;
                state_n    = RSP;
            end
            RSP: begin
                if (rsp_fire) begin
                    done_n  = (done == count) ? done : done + 1'b1;
                    addr_n  = addr + 16'd1;
                    state_n = (done_n == count) ? STATUS : ADDR;
                end
            end
            DRAIN: begin
                if (cmd_fire) begin
                    remain_n = remain - 1'b1;
                    if (remain_n == '0) state_n = STATUS;
                end
            end
            STATUS: begin
                if (rsp_fire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state_n == ADDR)   reg_data_n = {16'h0, addr_n};
        if (state_n == STATUS) rsp_data_n = {STATUS_TAG, ill_n, bad_hdr_n, 6'b0, 8'(done_n), addr_n[7:0]};
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            op             <= 1'b0;
            count          <= '0;
            done           <= '0;
            remain         <= '0;
            addr           <= '0;
            ill            <= 1'b0;
            bad_hdr        <= 1'b0;
            bus.cmd_ready  <= 1'b1;
            bus.reg_data   <= '0;
            bus.reg_num_le <= 1'b0;
            bus.reg_wr_en  <= 1'b0;
            bus.reg_rd_en  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_valid  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            op             <= op_n;
            count          <= count_n;
            done           <= done_n;
            remain         <= remain_n;
            addr           <= addr_n;
            ill            <= ill_n;
            bad_hdr        <= bad_hdr_n;
            bus.cmd_ready  <= (state_n == IDLE) || (state_n == WDATA) || (state_n == DRAIN);
            bus.reg_data   <= reg_data_n;
            bus.reg_num_le <= (state_n == ADDR);
            bus.reg_wr_en  <= (state_n == WR);
            bus.reg_rd_en  <= (state_n == RD);
            bus.rsp_data   <= rsp_data_n;
            bus.rsp_valid  <= (state_n == RSP) || (state_n == STATUS);
            busy           <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Bench for reg_cmd_sequencer: 16-register block model, queue-based response scoreboard,
// directed command cases followed by randomized bursts.
module tb_reg_cmd_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    reg_cmd_sequencer_if bus();

    reg_cmd_sequencer #(.CNT_W(8), .STATUS_TAG(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy)
    );

    always #4 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Register block model: 16 registers, illegal flag registered with the number latch.
    logic [31:0] rb_num = '0;
    logic        rb_ill = 1'b0;
    logic [31:0] rb_tx  = '0;
    logic [31:0] rb_regs [16];

    assign bus.reg_illegal = rb_ill;
    assign bus.reg_rdata   = rb_tx;

    always @(posedge clk) begin
        if (bus.reg_num_le) begin
            rb_num <= bus.reg_data;
            rb_ill <= (bus.reg_data > 32'd15);
        end
        if (bus.reg_wr_en && rb_num < 32'd16) rb_regs[rb_num[3:0]] <= bus.reg_data;
        if (bus.reg_rd_en) rb_tx <= (rb_num < 32'd16) ? rb_regs[rb_num[3:0]] : 32'h0;
    end

    // Reference state
    logic [31:0] ref_regs [16];
    logic [31:0] exp_q [$];
    logic [31:0] data_q [$];
    logic [31:0] last_rsp = '0;
    int obs_le = 0, obs_wr = 0, obs_rd = 0;
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // rsp_ready: 0 random, 1 held low, 2 held high
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = ($urandom_range(0, 9) < 6);
                1:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: response scoreboard, hold-while-stalled and strobe exclusivity.
    initial begin
        bit          stall;
        logic [31:0] held;
        int          ns;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("rsp_hold_vld", {31'b0, bus.rsp_valid}, 32'd1);
                    chk("rsp_hold_dat", bus.rsp_data, held);
                end
                ns = int'(bus.reg_num_le) + int'(bus.reg_wr_en) + int'(bus.reg_rd_en);
                chk("strobe_overlap", (ns > 1) ? 32'd1 : 32'd0, 32'd0);
                if (bus.reg_num_le) obs_le++;
                if (bus.reg_wr_en)  obs_wr++;
                if (bus.reg_rd_en)  obs_rd++;
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL rsp_unexpected: got %08h expected no response", bus.rsp_data);
                    end else begin
                        chk("rsp_word", bus.rsp_data, exp_q.pop_front());
                    end
                    last_rsp = bus.rsp_data;
                end
                stall = bus.rsp_valid && !bus.rsp_ready;
                held  = bus.rsp_data;
            end
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send_word(input logic [31:0] w);
        bit ok;
        int g;
        ok = 1'b0;
        g  = $urandom_range(0, 2);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = w;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (!ok) begin
            n_total++;
            n_bad++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 500 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            n_bad++;
            $display("FAIL idle_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Command-level reference: walk the burst register by register.
    task automatic issue(input logic [31:0] hdr);
        logic [15:0] a;
        logic [31:0] done;
        logic        ill, badh;
        int          n, e_le, e_wr, e_rd;
        badh = (hdr[30:24] != 7'd0);
        n    = int'(hdr[23:16]);
        a    = hdr[15:0];
        done = 0;
        ill  = 1'b0;
        e_le = 0; e_wr = 0; e_rd = 0;
        if (!badh) begin
            for (int i = 0; i < n; i++) begin
                e_le++;
                if (a > 16'd15) begin
                    ill = 1'b1;
                    break;
                end
                if (hdr[31]) begin
                    exp_q.push_back(ref_regs[a[3:0]]);
                    e_rd++;
                end else begin
                    ref_regs[a[3:0]] = data_q[i];
                    e_wr++;
                end
                done++;
                a++;
            end
        end
        exp_q.push_back({8'hA5, ill, badh, 6'b0, done[7:0], a[7:0]});
        obs_le = 0; obs_wr = 0; obs_rd = 0;
        send_word(hdr);
        if (!badh && !hdr[31]) begin
            for (int i = 0; i < n; i++) send_word(data_q[i]);
        end
        wait_idle();
        chk("num_le_count", obs_le, e_le);
        chk("wr_en_count", obs_wr, e_wr);
        chk("rd_en_count", obs_rd, e_rd);
        for (int i = 0; i < 16; i++) chk($sformatf("reg_r%0d", i), rb_regs[i], ref_regs[i]);
    endtask

    task automatic fill_data(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back($urandom);
    endtask

    initial begin
        bit          ok;
        logic [31:0] hdr;
        int          r, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset_strobes", {29'b0, bus.reg_num_le, bus.reg_wr_en, bus.reg_rd_en}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        fill_data(16);
        issue(32'h0010_0000);

        data_q.delete();
        data_q.push_back(32'h1234_5678);
        issue(32'h0001_0003);
        chk("t1_status", last_rsp, 32'hA500_0104);

        fill_data(3);
        issue(32'h0003_0000);
        issue(32'h8003_0000);
        chk("t2_status", last_rsp, 32'hA500_0303);

        fill_data(4);
        issue(32'h0004_000E);
        chk("t3_status", last_rsp, 32'hA580_0210);

        data_q.delete();
        issue(32'h4000_0005);
        chk("t4_status", last_rsp, 32'hA540_0005);
        issue(32'h0000_0007);
        chk("t5_status", last_rsp, 32'hA500_0007);

        // Reset while a read response is being held.
        rdy_mode = 1;
        send_word(32'h8001_0000);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_reached_rsp", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rsp_valid_in_reset", {31'b0, bus.rsp_valid}, 32'd0);
        chk("t6_busy_in_reset", {31'b0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_cmd_ready_after", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        data_q.delete();
        data_q.push_back(32'h1234_5678);
        issue(32'h0001_0003);
        chk("t6_t1_status", last_rsp, 32'hA500_0104);

        for (int k = 0; k < 40; k++) begin
            r   = $urandom_range(0, 9);
            n   = (r == 1) ? 0 : $urandom_range(1, 6);
            hdr = {$urandom_range(0, 1) == 1, 7'd0, 8'(n), 16'($urandom_range(0, 17))};
            if (r == 0) hdr[30:24] = 7'($urandom_range(1, 127));
            fill_data(n);
            issue(hdr);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
